issue_stage: RTL and testbench

- Stage directly downstream of fetch/decode.
- Takes decoded fields (rs1, rs2, rd, imm, 12-bit code, pc), checks RAW hazards against a register scoreboard, and holds the instruction in a one-entry output register until execute accepts it.
- Valid/ready on both sides; flush input for taken branches; saturating stall counter for performance monitoring.

---
 rtl/issue_stage_pkg.sv | 8 +
 rtl/issue_stage_scoreboard.sv | 39 +++
 rtl/issue_stage.sv | 125 ++++++++++++
 tb/tb_issue_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_stage_pkg.sv
// Shared widths and defaults for the issue stage and its register scoreboard.
package issue_stage_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_W     = 5;
    localparam int CODE_W    = 12;
    localparam int STALL_W   = 32;
endpackage

// File: rtl/issue_stage_scoreboard.sv
// Register busy scoreboard: one set port (issue), one clear port (writeback),
// two combinational read ports that see a same-cycle writeback as already clear.
module issue_stage_scoreboard
    import issue_stage_pkg::*;
#(
    parameter int NREGS = NREGS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic [REG_W-1:0] set_rd_i,
    input  logic             clr_i,
    input  logic [REG_W-1:0] clr_rd_i,
    input  logic [REG_W-1:0] rd_a_i,
    input  logic [REG_W-1:0] rd_b_i,
    output logic             eff_a_o,
    output logic             eff_b_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is applied after clear so a new writer wins over a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_rd_i] = 1'b0;
        if (set_i) busy_d[set_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign eff_a_o = busy_q[rd_a_i] & ~(clr_i & (clr_rd_i == rd_a_i));
    assign eff_b_o = busy_q[rd_b_i] & ~(clr_i & (clr_rd_i == rd_b_i));

endmodule

// File: rtl/issue_stage.sv
// Issue stage: RAW hazard check against the scoreboard and the held entry,
// one-entry output register with valid/ready, flush, and a saturating stall counter.
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [REG_W-1:0]   in_rs1,
    input  logic [REG_W-1:0]   in_rs2,
    input  logic [REG_W-1:0]   in_rd,
    input  logic               in_wen,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [CODE_W-1:0]  in_code,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [REG_W-1:0]   out_rs1,
    output logic [REG_W-1:0]   out_rs2,
    output logic [REG_W-1:0]   out_rd,
    output logic               out_wen,
    output logic [XLEN-1:0]    out_imm,
    output logic [CODE_W-1:0]  out_code,
    output logic [XLEN-1:0]    out_pc,
    input  logic               wb_valid,
    input  logic [REG_W-1:0]   wb_rd,
    input  logic               flush,
    output logic [STALL_W-1:0] stall_cnt
);

    logic               out_valid_q, out_valid_d;
    logic [REG_W-1:0]   out_rs1_q, out_rs2_q, out_rd_q;
    logic               out_wen_q;
    logic [XLEN-1:0]    out_imm_q, out_pc_q;
    logic [CODE_W-1:0]  out_code_q;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic eff_rs1, eff_rs2;
    logic hold_wr_rs1, hold_wr_rs2;
    logic haz_rs1, haz_rs2, hazard;
    logic accept, issue_wr;

    // A held entry leaving this cycle still counts as issued, even under flush.
    assign issue_wr = out_valid_q & out_ready & out_wen_q & (out_rd_q != '0);

    issue_stage_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_i    (issue_wr),
        .set_rd_i (out_rd_q),
        .clr_i    (wb_valid),
        .clr_rd_i (wb_rd),
        .rd_a_i   (in_rs1),
        .rd_b_i   (in_rs2),
        .eff_a_o  (eff_rs1),
        .eff_b_o  (eff_rs2)
    );

    assign hold_wr_rs1 = out_valid_q & out_wen_q & (out_rd_q == in_rs1);
    assign hold_wr_rs2 = out_valid_q & out_wen_q & (out_rd_q == in_rs2);
    assign haz_rs1     = (in_rs1 != '0) & (eff_rs1 | hold_wr_rs1);
    assign haz_rs2     = (in_rs2 != '0) & (eff_rs2 | hold_wr_rs2);
    assign hazard      = haz_rs1 | haz_rs2;

    assign in_ready = ~flush & ~hazard & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)                  out_valid_d = 1'b0;
        else if (accept)            out_valid_d = 1'b1;
        else if (out_ready)         out_valid_d = 1'b0;
    end

    always_comb begin
        stall_d = stall_q;
        if (in_valid & hazard & ~flush & (stall_q != '1)) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

    // Payload only moves on accept; it is left stale while out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_rs1_q  <= '0;
            out_rs2_q  <= '0;
            out_rd_q   <= '0;
            out_wen_q  <= 1'b0;
            out_imm_q  <= '0;
            out_code_q <= '0;
            out_pc_q   <= '0;
        end else if (accept) begin
            out_rs1_q  <= in_rs1;
            out_rs2_q  <= in_rs2;
            out_rd_q   <= in_rd;
            out_wen_q  <= in_wen;
            out_imm_q  <= in_imm;
            out_code_q <= in_code;
            out_pc_q   <= in_pc;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rs1   = out_rs1_q;
    assign out_rs2   = out_rs2_q;
    assign out_rd    = out_rd_q;
    assign out_wen   = out_wen_q;
    assign out_imm   = out_imm_q;
    assign out_code  = out_code_q;
    assign out_pc    = out_pc_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the stage.
module tb_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic        in_wen = 1'b0;
    logic [31:0] in_imm = '0;
    logic [11:0] in_code = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_wen;
    logic [31:0] out_imm;
    logic [11:0] out_code;
    logic [31:0] out_pc;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic [31:0] stall_cnt;

    issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
        .in_imm(in_imm), .in_code(in_code), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_wen(out_wen),
        .out_imm(out_imm), .out_code(out_code), .out_pc(out_pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Behavioural model: set of busy registers, the held instruction, stall total.
    bit          m_busy[32];
    bit          m_valid;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    bit          m_wen;
    logic [31:0] m_imm, m_pc;
    logic [11:0] m_code;
    longint      m_stall;
    int          n_accepts;

    function automatic bit src_hazard(logic [4:0] s);
        if (s == 5'd0) return 1'b0;
        if (m_busy[s] && !(wb_valid && wb_rd == s)) return 1'b1;
        return m_valid && m_wen && (m_rd == s);
    endfunction

    function automatic bit model_ready();
        bit haz;
        haz = src_hazard(in_rs1) || src_hazard(in_rs2);
        return !flush && !haz && (!m_valid || out_ready);
    endfunction

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_valid = 0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_wen = 0;
        m_imm = '0; m_pc = '0; m_code = '0; m_stall = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_valid);
        chk("out_rs1", out_rs1, m_rs1);
        chk("out_rs2", out_rs2, m_rs2);
        chk("out_rd", out_rd, m_rd);
        chk("out_wen", out_wen, m_wen);
        chk("out_imm", out_imm, m_imm);
        chk("out_code", out_code, m_code);
        chk("out_pc", out_pc, m_pc);
        chk("stall_cnt", stall_cnt, m_stall);
    endtask

    // One clock with the currently driven inputs; model steps alongside the DUT.
    task automatic cycle();
        bit rdy, haz, acc, issued;
        #1;
        rdy = model_ready();
        haz = src_hazard(in_rs1) || src_hazard(in_rs2);
        chk("in_ready", in_ready, rdy);
        acc    = in_valid && rdy;
        issued = m_valid && out_ready;
        @(posedge clk);
        if (wb_valid && wb_rd != 0) m_busy[wb_rd] = 1'b0;
        if (issued && m_wen && m_rd != 0) m_busy[m_rd] = 1'b1;
        if (in_valid && haz && !flush && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (acc) begin
            m_valid = 1; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd; m_wen = in_wen;
            m_imm = in_imm; m_code = in_code; m_pc = in_pc;
            n_accepts++;
        end else if (flush || issued) begin
            m_valid = 0;
        end
        #1;
        check_outputs();
    endtask

    task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input bit wen);
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wen = wen;
        in_imm = $urandom; in_code = 12'($urandom); in_pc = $urandom;
    endtask

    task automatic idle_inputs();
        in_valid = 0; wb_valid = 0; flush = 0; out_ready = 1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_stall", stall_cnt, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    longint base;
    logic [31:0] held_pc;

    initial begin
        model_reset();
        n_accepts = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Independent stream: four writers, one accepted per cycle.
        idle_inputs();
        n_accepts = 0;
        for (int i = 1; i <= 4; i++) begin
            drive_instr(5'd0, 5'd0, 5'(i), 1'b1);
            cycle();
            chk("stream_valid", out_valid, 1'b1);
        end
        chk("stream_accepts", n_accepts, 4);
        idle_inputs(); cycle();
        chk("stream_stall", stall_cnt, 32'd0);
        for (int r = 1; r <= 4; r++) begin
            wb_valid = 1; wb_rd = 5'(r); cycle();
        end
        idle_inputs(); cycle();

        // RAW stall on r3 for three cycles, released by its writeback.
        base = m_stall;
        drive_instr(5'd0, 5'd0, 5'd3, 1'b1); cycle();
        drive_instr(5'd3, 5'd0, 5'd4, 1'b1);
        repeat (3) cycle();
        chk("raw_stalled", out_rd, 5'd3);
        wb_valid = 1; wb_rd = 5'd3;
        cycle();
        chk("raw_accept_rd", out_rd, 5'd4);
        chk("raw_stall_cycles", stall_cnt - 32'(base), 32'd3);
        idle_inputs(); wb_valid = 1; wb_rd = 5'd4; cycle();
        idle_inputs(); cycle();

        // Backpressure: held entry stays put, then moves on the same cycle a new one enters.
        drive_instr(5'd0, 5'd0, 5'd0, 1'b0); cycle();
        held_pc = out_pc;
        out_ready = 0;
        drive_instr(5'd0, 5'd0, 5'd6, 1'b0);
        repeat (3) begin
            cycle();
            chk("bp_pc_stable", out_pc, held_pc);
        end
        out_ready = 1;
        cycle();
        chk("bp_new_rd", out_rd, 5'd6);

        // Flush a held writer to r7: it never issued, so r7 stays free.
        drive_instr(5'd0, 5'd0, 5'd7, 1'b1); cycle();
        in_valid = 0; out_ready = 0; flush = 1; cycle();
        chk("flush_valid", out_valid, 1'b0);
        flush = 0; out_ready = 1;
        drive_instr(5'd7, 5'd0, 5'd8, 1'b0);
        #1; chk("flush_no_busy", in_ready, 1'b1);
        cycle();
        idle_inputs(); cycle();

        // x0 never hazards; issue and writeback of r9 in one cycle leaves r9 busy.
        drive_instr(5'd0, 5'd0, 5'd0, 1'b1); cycle();
        drive_instr(5'd0, 5'd0, 5'd9, 1'b1);
        #1; chk("x0_ready", in_ready, 1'b1);
        cycle();
        in_valid = 0; wb_valid = 1; wb_rd = 5'd9; cycle();
        wb_valid = 0;
        drive_instr(5'd9, 5'd0, 5'd1, 1'b0);
        #1; chk("race_busy9", in_ready, 1'b0);
        cycle();
        wb_valid = 1; wb_rd = 5'd9; cycle();
        idle_inputs(); cycle();

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_rs1    = 5'($urandom_range(0, 7));
            in_rs2    = 5'($urandom_range(0, 7));
            in_rd     = 5'($urandom_range(0, 7));
            in_wen    = ($urandom_range(0, 3) != 0);
            in_imm    = $urandom;
            in_code   = 12'($urandom);
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            wb_valid  = ($urandom_range(0, 1) == 1);
            wb_rd     = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end

        // Reset mid-stream with an entry held: drop it immediately.
        idle_inputs(); out_ready = 0;
        drive_instr(5'd0, 5'd0, 5'd5, 1'b1); cycle();
        drive_instr(5'd1, 5'd0, 5'd2, 1'b1); cycle();
        chk("pre_rst_valid", out_valid, 1'b1);
        #2;
        apply_reset();
        idle_inputs();
        drive_instr(5'd5, 5'd0, 5'd1, 1'b0);
        #1; chk("post_rst_ready", in_ready, 1'b1);
        cycle();
        idle_inputs(); cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
